// File: rtl/sysid_probe_master_if.sv
// Avalon-MM read-only port between the system-ID probe master and the sysid slave.
interface sysid_probe_master_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/sysid_probe_master.sv
// Reads the sysid ID and timestamp words, compares them with build-time constants
// and reports match/timeout status with a retry policy on unresponsive slaves.
module sysid_probe_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1444878925,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  sysid_probe_master_if.master        avm,
  output logic                        busy,
  output logic                        done,
  output logic                        id_match,
  output logic                        ts_match,
  output logic                        timeout,
  output logic [31:0]                 id_value,
  output logic [31:0]                 ts_value
);

  typedef enum logic [2:0] {IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, CHECK} state_t;

  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

  state_t      state, state_nx;
  logic [15:0] timer;
  logic [3:0]  retry_cnt;
  logic        in_req, in_wait, accept, resp, tmo_evt, retry, enter_req;
  state_t      tmo_target;

  always_comb begin
    in_req     = (state == ID_REQ) || (state == TS_REQ);
    in_wait    = (state == ID_WAIT) || (state == TS_WAIT);
    accept     = in_req && !avm.avm_waitrequest;
    // A zero-latency slave may return data in the accept cycle itself.
    resp       = (accept || in_wait) && avm.avm_readdatavalid;
    tmo_evt    = ((in_req && !accept) || (in_wait && !resp)) && (timer >= TMO_LAST);
    retry      = tmo_evt && (retry_cnt < RETRY_MAX);
    tmo_target = retry ? ID_REQ : CHECK;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = ID_REQ;
      ID_REQ:  if (tmo_evt) state_nx = tmo_target;
               else if (resp) state_nx = TS_REQ;
               else if (accept) state_nx = ID_WAIT;
      ID_WAIT: if (tmo_evt) state_nx = tmo_target;
               else if (resp) state_nx = TS_REQ;
      TS_REQ:  if (tmo_evt) state_nx = tmo_target;
               else if (resp) state_nx = CHECK;
               else if (accept) state_nx = TS_WAIT;
      TS_WAIT: if (tmo_evt) state_nx = tmo_target;
               else if (resp) state_nx = CHECK;
      CHECK:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy            = in_req || in_wait;
    done            = (state == CHECK);
    avm.avm_read    = in_req;
    avm.avm_address = (state == TS_REQ);
  end

  // A retry re-enters ID_REQ from itself, so entry is not just a state change.
  assign enter_req = ((state_nx == ID_REQ) || (state_nx == TS_REQ)) &&
                     ((state_nx != state) || retry);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer     <= '0;
      retry_cnt <= '0;
      id_match  <= 1'b0;
      ts_match  <= 1'b0;
      timeout   <= 1'b0;
      id_value  <= '0;
      ts_value  <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        retry_cnt <= '0;
        id_match  <= 1'b0;
        ts_match  <= 1'b0;
        timeout   <= 1'b0;
        id_value  <= '0;
        ts_value  <= '0;
      end

      if (enter_req)  timer <= '0;
      else if (busy)  timer <= timer + 16'd1;

      if (retry) begin
        retry_cnt <= retry_cnt + 4'd1;
        id_value  <= '0;
        ts_value  <= '0;
      end else if (tmo_evt) begin
        timeout <= 1'b1;
      end

      if (resp) begin
        if ((state == ID_REQ) || (state == ID_WAIT)) id_value <= avm.avm_readdata;
        else                                         ts_value <= avm.avm_readdata;
      end

      if (state == CHECK) begin
        id_match <= !timeout && (id_value == EXPECTED_ID);
        ts_match <= !timeout && (ts_value == EXPECTED_TIMESTAMP);
      end
    end
  end

endmodule

// File: tb/tb_sysid_probe_master.sv
// Scoreboard bench for sysid_probe_master driven by a configurable sysid slave model.
module tb_sysid_probe_master;

  localparam logic [31:0] TS_OK = 32'd1444878925;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, id_match, ts_match, timeout;
  logic [31:0] id_value, ts_value;

  sysid_probe_master_if bus ();

  sysid_probe_master #(
    .TIMEOUT_CYCLES (8),
    .MAX_RETRIES    (2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .avm      (bus),
    .busy     (busy),
    .done     (done),
    .id_match (id_match),
    .ts_match (ts_match),
    .timeout  (timeout),
    .id_value (id_value),
    .ts_value (ts_value)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Slave model
  int          wr_cycles = 0;
  int          lat       = 0;
  int          id_fail   = 0;
  logic        respond   = 1'b1;
  logic        slave_clr = 1'b0;
  logic [31:0] id_data   = 32'd0;
  logic [31:0] ts_data   = TS_OK;
  int          wr_cnt    = 0;
  int          pend      = 0;
  int          id_accepts = 0;
  logic        pend_addr = 1'b0;
  logic        acc, ok;

  assign bus.avm_waitrequest   = bus.avm_read && (wr_cnt < wr_cycles);
  assign acc                   = bus.avm_read && !bus.avm_waitrequest;
  assign ok                    = respond && !((bus.avm_address == 1'b0) && (id_accepts < id_fail));
  assign bus.avm_readdatavalid = (acc && (lat == 0) && ok) || (pend == 1);
  assign bus.avm_readdata      = (pend == 1) ? (pend_addr ? ts_data : id_data)
                                             : (bus.avm_address ? ts_data : id_data);

  always @(posedge clock) begin
    if (slave_clr) begin
      wr_cnt     <= 0;
      pend       <= 0;
      id_accepts <= 0;
    end else begin
      if (bus.avm_read && bus.avm_waitrequest) wr_cnt <= wr_cnt + 1;
      else                                     wr_cnt <= 0;
      if (acc && (bus.avm_address == 1'b0)) id_accepts <= id_accepts + 1;
      if (acc && (lat > 0) && ok) begin
        pend      <= lat;
        pend_addr <= bus.avm_address;
      end else if (pend > 0) begin
        pend <= pend - 1;
      end
    end
  end

  // Scoreboard
  typedef struct {
    logic        idm;
    logic        tsm;
    logic        tmo;
    logic [31:0] idv;
    logic [31:0] tsv;
  } exp_t;

  exp_t sb[$];
  logic chk_pend = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (chk_pend) begin
      check("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("id_match", id_match, e.idm);
        check("ts_match", ts_match, e.tsm);
        check("timeout",  timeout,  e.tmo);
        check("id_value", id_value, e.idv);
        check("ts_value", ts_value, e.tsv);
      end
    end
    chk_pend <= done && !reset;
  end

  // Request must stay stable while the slave stalls
  logic prev_stall = 1'b0;
  logic prev_addr  = 1'b0;

  always @(negedge clock) begin
    if (prev_stall && !reset) begin
      check("read_held", bus.avm_read, 1'b1);
      check("addr_held", bus.avm_address, prev_addr);
    end
    prev_stall <= bus.avm_read && bus.avm_waitrequest && !reset;
    prev_addr  <= bus.avm_address;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input exp_t e, input int poke, output int n);
    sb.push_back(e);
    start = 1'b1;
    cyc();
    start = 1'b0;
    n = 1;
    while (!done && n < 200) begin
      start = (n == poke);
      cyc();
      n++;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
    cyc();
    cyc();
  endtask

  task automatic config_slave(input int w, input int l, input logic r, input int f);
    wr_cycles = w;
    lat       = l;
    respond   = r;
    id_fail   = f;
    slave_clr = 1'b1;
    cyc();
    slave_clr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    check("rst_busy",     busy,         1'b0);
    check("rst_done",     done,         1'b0);
    check("rst_read",     bus.avm_read, 1'b0);
    check("rst_id_match", id_match,     1'b0);
    check("rst_ts_match", ts_match,     1'b0);
    check("rst_timeout",  timeout,      1'b0);
    check("rst_id_value", id_value,     32'd0);
    check("rst_ts_value", ts_value,     32'd0);

    // 1: zero-latency slave, exact cycle timing, start in CHECK ignored
    config_slave(0, 0, 1'b1, 0);
    sb.push_back('{1'b1, 1'b1, 1'b0, 32'd0, TS_OK});
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("t1_busy_c1", busy, 1'b1);
    check("t1_done_c1", done, 1'b0);
    cyc();
    check("t1_busy_c2", busy, 1'b1);
    check("t1_done_c2", done, 1'b0);
    cyc();
    check("t1_done_c3", done, 1'b1);
    check("t1_busy_c3", busy, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("t1_start_in_check_ignored", busy, 1'b0);
    cyc();
    cyc();

    // 2: 5-cycle waitrequest, readdatavalid 2 cycles after accept, start while busy
    config_slave(5, 2, 1'b1, 0);
    issue('{1'b1, 1'b1, 1'b0, 32'd0, TS_OK}, 4, n);
    check("t2_latency", n, 17);

    // 3: wrong timestamp
    ts_data = 32'h12345678;
    config_slave(0, 0, 1'b1, 0);
    issue('{1'b1, 1'b0, 1'b0, 32'd0, 32'h12345678}, 0, n);
    check("t3_latency", n, 3);
    ts_data = TS_OK;

    // 4: slave accepts but never responds
    config_slave(0, 1, 1'b0, 0);
    issue('{1'b0, 1'b0, 1'b1, 32'd0, 32'd0}, 0, n);
    check("t4_latency", n, 25);
    check("t4_id_reads", 32'(id_accepts), 32'd3);

    // 5: first ID read times out, retry succeeds
    config_slave(0, 1, 1'b1, 1);
    issue('{1'b1, 1'b1, 1'b0, 32'd0, TS_OK}, 0, n);
    check("t5_latency", n, 13);
    check("t5_id_reads", 32'(id_accepts), 32'd2);

    // 6: reset asserted in TS_WAIT
    id_data = 32'h000000A5;
    config_slave(0, 2, 1'b1, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    check("t6_busy_pre",     busy,     1'b1);
    check("t6_id_value_pre", id_value, 32'h000000A5);
    reset = 1'b1;
    #1;
    check("t6_busy_async",     busy,         1'b0);
    check("t6_read_async",     bus.avm_read, 1'b0);
    check("t6_id_value_async", id_value,     32'd0);
    check("t6_ts_value_async", ts_value,     32'd0);
    check("t6_timeout_async",  timeout,      1'b0);
    cyc();
    check("t6_no_done_a", done, 1'b0);
    cyc();
    check("t6_no_done_b", done, 1'b0);
    reset = 1'b0;
    repeat (3) cyc();
    check("t6_idle_after", busy, 1'b0);
    id_data = 32'd0;
    config_slave(0, 2, 1'b1, 0);
    issue('{1'b1, 1'b1, 1'b0, 32'd0, TS_OK}, 0, n);
    check("t6_latency", n, 7);

    repeat (3) cyc();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
